axil_command_initiator: RTL and testbench
=========================================

AXIL_COMMAND_INITIATOR -- requirements
Module: axil_command_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-lite and command address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-lite and command data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, response-wait limit in clock cycles.
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_address  input  ADDR_WIDTH  target address.
REQ-010 SHALL have port cmd_data  input  DATA_WIDTH  write data; ignored for reads.
REQ-011 SHALL have port rsp_valid  output  1  completion available.
REQ-012 SHALL have port rsp_ready  input  1  completion consumed when rsp_valid and rsp_ready are both high.
REQ-013 SHALL have port rsp_data  output  DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port rsp_error  output  1  BRESP/RRESP was not OKAY.
REQ-015 SHALL have port rsp_timeout  output  1  no response within TIMEOUT_CYCLES.
REQ-016 SHALL have port axil  interface  axi_lite (master side)  AXI-lite initiator bus.

Function
REQ-017 SHALL use FSM states IDLE, WRITE_ADDR_DATA, WRITE_RESP, READ_ADDR, READ_DATA, RESPOND.
REQ-018 SHALL drive cmd_ready high only in IDLE with no stale beat pending (REQ-027).
REQ-019 SHALL latch address/data on acceptance and assert AWVALID+WVALID (write) or ARVALID (read) the following cycle.
REQ-020 SHALL hold AWVALID, WVALID, ARVALID each stable until its own handshake, then drop it independently; a valid never deasserts before its handshake.
REQ-021 SHALL move WRITE_ADDR_DATA to WRITE_RESP once both AW and W have completed, in any order, including the same cycle.
REQ-022 SHALL assert BREADY in WRITE_RESP and RREADY in READ_DATA; a B or R handshake moves to RESPOND and captures RDATA (read) plus RESP != 2'b00 into rsp_error.
REQ-023 SHALL assert rsp_valid in RESPOND, hold rsp_data/rsp_error/rsp_timeout stable until rsp_ready, and return to IDLE on that handshake.
REQ-024 SHALL achieve minimum command-accept-to-rsp_valid latency of 3 cycles with a zero-wait slave.
REQ-025 SHALL support back-to-back operation: a new command may be accepted the cycle after the rsp handshake.
REQ-026 SHALL drive ARPROT/AWPROT = 0 and WSTRB all-ones.

Reset
REQ-027 SHALL force on reset low: FSM IDLE; rsp_valid, rsp_error, rsp_timeout, AWVALID, WVALID, ARVALID, BREADY, RREADY = 0; rsp_data and latched registers = 0; stale flags cleared.
REQ-028 SHALL abandon any in-flight transaction when reset asserts mid-operation and issue no response for it.

Configuration
REQ-029 SHALL compile in the timeout feature when macro AXIL_INITIATOR_TIMEOUT_EN is defined.
REQ-030 With the macro, SHALL count cycles spent in WRITE_RESP or READ_DATA; on reaching TIMEOUT_CYCLES without handshake, SHALL enter RESPOND with rsp_timeout=1, rsp_error=0, rsp_data=0.
REQ-031 With the macro, SHALL set a stale flag per channel on timeout, keep BREADY/RREADY high while that flag is set, discard the late beat, clear the flag on it, and hold cmd_ready low while any stale flag is set.
REQ-032 Without the macro, SHALL wait for B/R indefinitely, tie rsp_timeout to 0, and contain no counter logic.

Structure
REQ-033 SHALL place the FSM state enum and AXI RESP constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) in package axil_initiator_pkg.
REQ-034 SHALL implement the timeout counter as sub-module axil_timeout_counter (clear, enable, expired), instantiated only under AXIL_INITIATOR_TIMEOUT_EN.

Verification
REQ-035 SHALL cover write 0x00000004 / 0xDEADBEEF through the crossbar into a register slave -> slave register 1 = 0xDEADBEEF; rsp_valid with error=0, timeout=0.
REQ-036 SHALL cover read back 0x00000004 -> rsp_data = 0xDEADBEEF; latency 3 cycles with zero-wait slave.
REQ-037 SHALL cover a slave that accepts W two cycles before AW -> exactly one AW and one W handshake, single response.
REQ-038 SHALL cover a slave returning RRESP=2'b10 on a read of 0x30000000 -> rsp_error=1, rsp_data as returned.
REQ-039 SHALL cover, with AXIL_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that withholds BVALID 20 cycles -> rsp_timeout=1 after 8 cycles, cmd_ready low until the late B is consumed, then high.
REQ-040 SHALL cover reset asserted while AWVALID is high -> all valids 0 the same cycle, no rsp_valid, cmd_ready high after release.

Source files
------------

// File: rtl/axil_initiator_pkg.sv
// Shared types for the AXI-lite command initiator: FSM state encoding,
// AXI response codes and a response classification helper.
package axil_initiator_pkg;

   typedef enum logic [2:0] {
      IDLE            = 3'd0,
      WRITE_ADDR_DATA = 3'd1,
      WRITE_RESP      = 3'd2,
      READ_ADDR       = 3'd3,
      READ_DATA       = 3'd4,
      RESPOND         = 3'd5
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic resp_is_error(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/axi_lite.sv
// AXI-lite bus bundle with master and slave views.
interface axi_lite #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    awvalid;
   logic                    awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    bvalid;
   logic                    bready;
   logic [1:0]              bresp;
   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_timeout_counter.sv
// Saturating wait counter; expired is high during the TIMEOUT_CYCLES-th
// consecutive enabled cycle so the owner can leave its wait state on that edge.
module axil_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_r;

   // Count enabled cycles, holding at the last value until cleared.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r <= {CW{1'b0}};
      end else if (clear) begin
         count_r <= {CW{1'b0}};
      end else if (enable && (count_r != LAST)) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = enable && (count_r == LAST);
endmodule

// File: rtl/axil_command_initiator.sv
// Single-outstanding command-to-AXI-lite initiator. Define AXIL_INITIATOR_TIMEOUT_EN
// to add a response-wait timeout with late-beat (stale) draining.
module axil_command_initiator
   import axil_initiator_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_address,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_error,
   output logic                  rsp_timeout,
   axi_lite.master               axil
);
   state_e                state_r, next_state_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r, cmd_ready_r;
   logic rsp_valid_r, rsp_error_r, rsp_timeout_r;
   logic [DATA_WIDTH-1:0] rsp_data_r;
   logic awvalid_nxt_s, wvalid_nxt_s, arvalid_nxt_s, bready_nxt_s, rready_nxt_s;
   logic cmd_ready_nxt_s, rsp_valid_nxt_s, rsp_error_nxt_s, rsp_timeout_nxt_s;
   logic [DATA_WIDTH-1:0] rsp_data_nxt_s;
   logic accept_s, aw_complete_s, w_complete_s, ar_hs_s, b_hs_s, r_hs_s;
   logic timeout_s, stale_b_nxt_s, stale_r_nxt_s;

   assign accept_s      = cmd_valid && cmd_ready_r;
   assign aw_complete_s = !awvalid_r || axil.awready;
   assign w_complete_s  = !wvalid_r || axil.wready;
   assign ar_hs_s       = arvalid_r && axil.arready;
   assign b_hs_s        = axil.bvalid && bready_r;
   assign r_hs_s        = axil.rvalid && rready_r;

`ifdef AXIL_INITIATOR_TIMEOUT_EN
   logic stale_b_r, stale_r_r, wait_s;

   assign wait_s = (state_r == WRITE_RESP) || (state_r == READ_DATA);

   axil_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (!wait_s),
      .enable  (wait_s),
      .expired (timeout_s)
   );

   // A timed-out channel stays stale until its late beat has been drained.
   always_comb begin
      stale_b_nxt_s = stale_b_r;
      stale_r_nxt_s = stale_r_r;
      if ((state_r == WRITE_RESP) && !b_hs_s && timeout_s) begin
         stale_b_nxt_s = 1'b1;
      end else if (stale_b_r && b_hs_s) begin
         stale_b_nxt_s = 1'b0;
      end else begin
         stale_b_nxt_s = stale_b_r;
      end
      if ((state_r == READ_DATA) && !r_hs_s && timeout_s) begin
         stale_r_nxt_s = 1'b1;
      end else if (stale_r_r && r_hs_s) begin
         stale_r_nxt_s = 1'b0;
      end else begin
         stale_r_nxt_s = stale_r_r;
      end
   end

   // Stale flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stale_b_r <= 1'b0;
         stale_r_r <= 1'b0;
      end else begin
         stale_b_r <= stale_b_nxt_s;
         stale_r_r <= stale_r_nxt_s;
      end
   end
`else
   assign timeout_s     = 1'b0;
   assign stale_b_nxt_s = 1'b0;
   assign stale_r_nxt_s = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic; AW and W may complete in either order.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) next_state_s = cmd_write ? WRITE_ADDR_DATA : READ_ADDR;
            else          next_state_s = IDLE;
         end
         WRITE_ADDR_DATA: begin
            if (aw_complete_s && w_complete_s) next_state_s = WRITE_RESP;
            else                               next_state_s = WRITE_ADDR_DATA;
         end
         WRITE_RESP: begin
            if (b_hs_s || timeout_s) next_state_s = RESPOND;
            else                     next_state_s = WRITE_RESP;
         end
         READ_ADDR: begin
            if (ar_hs_s) next_state_s = READ_DATA;
            else         next_state_s = READ_ADDR;
         end
         READ_DATA: begin
            if (r_hs_s || timeout_s) next_state_s = RESPOND;
            else                     next_state_s = READ_DATA;
         end
         RESPOND: begin
            if (rsp_valid_r && rsp_ready) next_state_s = IDLE;
            else                          next_state_s = RESPOND;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // FSM output logic: next values for every registered output.
   always_comb begin
      awvalid_nxt_s     = awvalid_r;
      wvalid_nxt_s      = wvalid_r;
      arvalid_nxt_s     = arvalid_r;
      rsp_data_nxt_s    = rsp_data_r;
      rsp_error_nxt_s   = rsp_error_r;
      rsp_timeout_nxt_s = rsp_timeout_r;
      if (accept_s && cmd_write) begin
         awvalid_nxt_s = 1'b1;
         wvalid_nxt_s  = 1'b1;
      end else begin
         awvalid_nxt_s = awvalid_r && !axil.awready;
         wvalid_nxt_s  = wvalid_r && !axil.wready;
      end
      if (accept_s && !cmd_write) arvalid_nxt_s = 1'b1;
      else                        arvalid_nxt_s = arvalid_r && !axil.arready;
      if ((state_r == WRITE_RESP) && b_hs_s) begin
         rsp_data_nxt_s    = {DATA_WIDTH{1'b0}};
         rsp_error_nxt_s   = resp_is_error(axil.bresp);
         rsp_timeout_nxt_s = 1'b0;
      end else if ((state_r == READ_DATA) && r_hs_s) begin
         rsp_data_nxt_s    = axil.rdata;
         rsp_error_nxt_s   = resp_is_error(axil.rresp);
         rsp_timeout_nxt_s = 1'b0;
      end else if (timeout_s) begin
         rsp_data_nxt_s    = {DATA_WIDTH{1'b0}};
         rsp_error_nxt_s   = 1'b0;
         rsp_timeout_nxt_s = 1'b1;
      end else begin
         rsp_data_nxt_s    = rsp_data_r;
         rsp_error_nxt_s   = rsp_error_r;
         rsp_timeout_nxt_s = rsp_timeout_r;
      end
      bready_nxt_s    = (next_state_s == WRITE_RESP) || stale_b_nxt_s;
      rready_nxt_s    = (next_state_s == READ_DATA) || stale_r_nxt_s;
      cmd_ready_nxt_s = (next_state_s == IDLE) && !stale_b_nxt_s && !stale_r_nxt_s;
      rsp_valid_nxt_s = (next_state_s == RESPOND);
   end

   // Output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         awvalid_r     <= 1'b0;
         wvalid_r      <= 1'b0;
         arvalid_r     <= 1'b0;
         bready_r      <= 1'b0;
         rready_r      <= 1'b0;
         cmd_ready_r   <= 1'b0;
         rsp_valid_r   <= 1'b0;
         rsp_error_r   <= 1'b0;
         rsp_timeout_r <= 1'b0;
         rsp_data_r    <= {DATA_WIDTH{1'b0}};
      end else begin
         awvalid_r     <= awvalid_nxt_s;
         wvalid_r      <= wvalid_nxt_s;
         arvalid_r     <= arvalid_nxt_s;
         bready_r      <= bready_nxt_s;
         rready_r      <= rready_nxt_s;
         cmd_ready_r   <= cmd_ready_nxt_s;
         rsp_valid_r   <= rsp_valid_nxt_s;
         rsp_error_r   <= rsp_error_nxt_s;
         rsp_timeout_r <= rsp_timeout_nxt_s;
         rsp_data_r    <= rsp_data_nxt_s;
      end
   end

   // Command latch, loaded on acceptance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_r <= {ADDR_WIDTH{1'b0}};
         data_r <= {DATA_WIDTH{1'b0}};
      end else if (accept_s) begin
         addr_r <= cmd_address;
         data_r <= cmd_data;
      end else begin
         addr_r <= addr_r;
         data_r <= data_r;
      end
   end

   assign cmd_ready    = cmd_ready_r;
   assign rsp_valid    = rsp_valid_r;
   assign rsp_data     = rsp_data_r;
   assign rsp_error    = rsp_error_r;
   assign rsp_timeout  = rsp_timeout_r;
   assign axil.awvalid = awvalid_r;
   assign axil.awaddr  = addr_r;
   assign axil.awprot  = 3'b000;
   assign axil.wvalid  = wvalid_r;
   assign axil.wdata   = data_r;
   assign axil.wstrb   = {(DATA_WIDTH/8){1'b1}};
   assign axil.bready  = bready_r;
   assign axil.arvalid = arvalid_r;
   assign axil.araddr  = addr_r;
   assign axil.arprot  = 3'b000;
   assign axil.rready  = rready_r;
endmodule

// File: tb/tb_axil_command_initiator.sv
// Directed + randomized bench for axil_command_initiator with an AXI-lite
// register slave whose per-channel wait states are adjustable.
module tb_axil_command_initiator;
   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_address, cmd_data;
   logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
   logic [31:0] rsp_data;

   axi_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil_if ();

   axil_command_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
      .axil(axil_if)
   );

   always #5 clock = ~clock;

   localparam logic [31:0] ERR_DATA = 32'hBADC0FFE;

   int n_checks = 0;
   int n_fail   = 0;
   int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
   logic [31:0] slv_mem [16];
   logic [31:0] ref_mem [16];

   function automatic logic addr_is_err(input logic [31:0] a);
      return (a[31:28] == 4'h3);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Register slave: samples handshakes on the edge, drives its outputs 1 time unit later.
   initial begin : slave
      logic [31:0] aw_q[$], w_q[$], ar_q[$];
      int aw_wait, w_wait, ar_wait, b_wait, r_wait;
      logic bv, rv;
      logic [1:0] br, rr;
      logic [31:0] a, d, rd;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      bv = 1'b0; rv = 1'b0; br = 2'b00; rr = 2'b00; rd = 32'd0;
      axil_if.awready = 1'b0; axil_if.wready = 1'b0; axil_if.arready = 1'b0;
      axil_if.bvalid = 1'b0; axil_if.bresp = 2'b00;
      axil_if.rvalid = 1'b0; axil_if.rresp = 2'b00; axil_if.rdata = 32'd0;
      forever begin
         @(posedge clock);
         if (!reset) begin
            aw_q.delete(); w_q.delete(); ar_q.delete();
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            bv = 1'b0; rv = 1'b0;
         end else begin
            if (axil_if.awvalid && axil_if.awready) begin
               aw_q.push_back(axil_if.awaddr); aw_hs_n++; aw_wait = 0;
            end else if (axil_if.awvalid) aw_wait++;
            if (axil_if.wvalid && axil_if.wready) begin
               w_q.push_back(axil_if.wdata); w_hs_n++; w_wait = 0;
            end else if (axil_if.wvalid) w_wait++;
            if (axil_if.arvalid && axil_if.arready) begin
               ar_q.push_back(axil_if.araddr); ar_hs_n++; ar_wait = 0;
            end else if (axil_if.arvalid) ar_wait++;
            if (axil_if.bvalid && axil_if.bready) begin b_hs_n++; bv = 1'b0; end
            if (axil_if.rvalid && axil_if.rready) begin r_hs_n++; rv = 1'b0; end
            if (!bv && aw_q.size() > 0 && w_q.size() > 0) begin
               if (b_wait >= b_delay) begin
                  a = aw_q.pop_front(); d = w_q.pop_front();
                  if (addr_is_err(a)) br = 2'b10;
                  else begin br = 2'b00; slv_mem[a[5:2]] = d; end
                  bv = 1'b1; b_wait = 0;
               end else b_wait++;
            end
            if (!rv && ar_q.size() > 0) begin
               if (r_wait >= r_delay) begin
                  a = ar_q.pop_front();
                  if (addr_is_err(a)) begin rr = 2'b10; rd = ERR_DATA; end
                  else begin rr = 2'b00; rd = slv_mem[a[5:2]]; end
                  rv = 1'b1; r_wait = 0;
               end else r_wait++;
            end
         end
         #1;
         axil_if.awready = reset && (aw_wait >= aw_delay);
         axil_if.wready  = reset && (w_wait >= w_delay);
         axil_if.arready = reset && (ar_wait >= ar_delay);
         axil_if.bvalid  = bv; axil_if.bresp = br;
         axil_if.rvalid  = rv; axil_if.rresp = rr; axil_if.rdata = rd;
      end
   end

   // Issue one command, check the response against the reference model.
   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input int hold, input logic exp_to, input logic exp_ready_after,
                         output int lat);
      int t;
      logic [31:0] exp_data;
      logic exp_err;
      if (exp_to) begin
         exp_data = 32'd0; exp_err = 1'b0;
      end else if (wr) begin
         exp_data = 32'd0; exp_err = addr_is_err(addr);
      end else begin
         exp_err  = addr_is_err(addr);
         exp_data = exp_err ? ERR_DATA : ref_mem[addr[5:2]];
      end
      if (wr && !addr_is_err(addr)) ref_mem[addr[5:2]] = data;
      @(negedge clock);
      cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_data = data;
      t = 0;
      while (!cmd_ready && t < 100) begin @(negedge clock); t++; end
      check_b("cmd_ready_wait", cmd_ready, 1'b1);
      @(negedge clock);
      cmd_valid = 1'b0; cmd_data = $urandom; cmd_address = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 200) begin @(negedge clock); lat++; end
      check_b("rsp_valid_wait", rsp_valid, 1'b1);
      check("rsp_data", rsp_data, exp_data);
      check_b("rsp_error", rsp_error, exp_err);
      check_b("rsp_timeout", rsp_timeout, exp_to);
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check_b("rsp_hold_valid", rsp_valid, 1'b1);
         check("rsp_hold_data", rsp_data, exp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      check_b("rsp_drop", rsp_valid, 1'b0);
      check_b("cmd_ready_after", cmd_ready, exp_ready_after);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int lat, aw0, w0, b0, t;
      logic [31:0] addr, data;
      logic wr;
      reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 32'd0;
      cmd_data = 32'd0; rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin slv_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
      repeat (3) @(negedge clock);
      check_b("rst_cmd_ready", cmd_ready, 1'b0);
      check_b("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check_b("rst_rsp_error", rsp_error, 1'b0);
      check_b("rst_rsp_timeout", rsp_timeout, 1'b0);
      check_b("rst_awvalid", axil_if.awvalid, 1'b0);
      check_b("rst_wvalid", axil_if.wvalid, 1'b0);
      check_b("rst_arvalid", axil_if.arvalid, 1'b0);
      check_b("rst_bready", axil_if.bready, 1'b0);
      check_b("rst_rready", axil_if.rready, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check_b("idle_cmd_ready", cmd_ready, 1'b1);
      check("awprot", 32'(axil_if.awprot), 32'd0);
      check("arprot", 32'(axil_if.arprot), 32'd0);
      check("wstrb", 32'(axil_if.wstrb), 32'hF);

      // Write then read back register 1 through a zero-wait slave.
      do_cmd(1'b1, 32'h0000_0004, 32'hDEADBEEF, 0, 1'b0, 1'b1, lat);
      check("wr_latency", 32'(lat), 32'd3);
      check("slave_reg1", slv_mem[1], 32'hDEADBEEF);
      do_cmd(1'b0, 32'h0000_0004, 32'd0, 0, 1'b0, 1'b1, lat);
      check("rd_latency", 32'(lat), 32'd3);

      // W accepted two cycles before AW.
      aw_delay = 2; aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
      do_cmd(1'b1, 32'h0000_0008, 32'h1234_5678, 0, 1'b0, 1'b1, lat);
      repeat (5) @(negedge clock);
      check_b("single_rsp", rsp_valid, 1'b0);
      check("aw_hs_count", 32'(aw_hs_n - aw0), 32'd1);
      check("w_hs_count", 32'(w_hs_n - w0), 32'd1);
      check("b_hs_count", 32'(b_hs_n - b0), 32'd1);
      aw_delay = 0;

      // Error response and response hold while rsp_ready is low.
      do_cmd(1'b0, 32'h3000_0000, 32'd0, 0, 1'b0, 1'b1, lat);
      do_cmd(1'b0, 32'h0000_0008, 32'd0, 4, 1'b0, 1'b1, lat);

      // Randomized traffic with random slave wait states.
      for (int n = 0; n < 16; n++) begin
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
         r_delay  = $urandom_range(0, 3);
         wr   = 1'($urandom_range(0, 1));
         addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 7) == 0) addr = addr | 32'h3000_0000;
         data = $urandom;
         do_cmd(wr, addr, data, $urandom_range(0, 2), 1'b0, 1'b1, lat);
      end
      aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;

      // Slave withholds BVALID for 20 cycles.
      b_delay = 20;
`ifdef AXIL_INITIATOR_TIMEOUT_EN
      do_cmd(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 1'b1, 1'b0, lat);
      check("timeout_latency", 32'(lat), 32'd10);
      check_b("stale_bready", axil_if.bready, 1'b1);
      t = 0;
      while (!(axil_if.bvalid && axil_if.bready) && t < 40) begin
         check_b("stale_cmd_ready", cmd_ready, 1'b0);
         @(negedge clock); t++;
      end
      check_b("late_b_seen", axil_if.bvalid && axil_if.bready, 1'b1);
      @(negedge clock);
      check_b("late_b_cmd_ready", cmd_ready, 1'b1);
      check_b("late_b_no_rsp", rsp_valid, 1'b0);
`else
      do_cmd(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 1'b0, 1'b1, lat);
      check("slow_b_latency", 32'(lat), 32'd23);
`endif
      b_delay = 0;
      do_cmd(1'b0, 32'h0000_0010, 32'd0, 0, 1'b0, 1'b1, lat);

      // Reset while AWVALID is high abandons the write.
      aw_delay = 6; w_delay = 6; aw0 = aw_hs_n;
      @(negedge clock);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'h0000_0014; cmd_data = 32'h5555_AAAA;
      @(negedge clock);
      cmd_valid = 1'b0;
      check_b("pre_rst_awvalid", axil_if.awvalid, 1'b1);
      #1 reset = 1'b0;
      #1;
      check_b("mid_rst_awvalid", axil_if.awvalid, 1'b0);
      check_b("mid_rst_wvalid", axil_if.wvalid, 1'b0);
      check_b("mid_rst_arvalid", axil_if.arvalid, 1'b0);
      @(negedge clock);
      reset = 1'b1; aw_delay = 0; w_delay = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_b("post_rst_no_rsp", rsp_valid, 1'b0);
      end
      check_b("post_rst_cmd_ready", cmd_ready, 1'b1);
      check("post_rst_aw_count", 32'(aw_hs_n - aw0), 32'd0);
      do_cmd(1'b0, 32'h0000_0014, 32'd0, 0, 1'b0, 1'b1, lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
